mult_div_unit: RTL and testbench

MULT_DIV_UNIT -- requirements
Module: mult_div_unit

---
 rtl/mdu_pkg.sv | 34 +++
 rtl/mult_div_unit.sv | 165 ++++++++++++++++
 tb/tb_mult_div_unit.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: op encodings, FSM states
// and a small op-classification helper.
package mdu_pkg;

  // 3-bit operation encodings presented on the op port.
  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MADD  = 3'd4,
    OP_MSUB  = 3'd5,
    OP_MTHI  = 3'd6,
    OP_MTLO  = 3'd7
  } op_e;

  // Controller states.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // Moves to HI/LO finish on the accepting edge and never enter RUN.
  function automatic logic is_move(input op_e op);
    return (op == OP_MTHI) || (op == OP_MTLO);
  endfunction

  // Divides use the divide latency; everything else arithmetic uses the
  // multiply latency.
  function automatic logic is_div(input op_e op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/mult_div_unit.sv
// HI/LO multiply/divide unit. The full result is computed combinationally at
// acceptance, parked in result_q, and committed to hi/lo when the latency
// counter expires. flush abandons the parked result.
module mult_div_unit
  import mdu_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int MUL_LAT = 5,
  parameter int DIV_LAT = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int W2 = 2 * WIDTH;

  // Latencies must fit the 8-bit down-counter and be non-zero.
  if (MUL_LAT < 1 || MUL_LAT > 255) begin : g_bad_mul_lat
    $error("mult_div_unit: MUL_LAT must be in 1..255");
  end
  if (DIV_LAT < 1 || DIV_LAT > 255) begin : g_bad_div_lat
    $error("mult_div_unit: DIV_LAT must be in 1..255");
  end

  localparam logic [7:0] MUL_CNT = 8'(MUL_LAT);
  localparam logic [7:0] DIV_CNT = 8'(DIV_LAT);

  state_e          state, next_state;
  logic [7:0]      count, next_count;
  logic            accept, commit;
  logic [W2-1:0]   result, result_q;

  op_e             op_sel;
  logic            arith;

  assign op_sel = op_e'(op);
  assign arith  = !is_move(op_sel);
  assign busy   = (state == ST_RUN);

  // Products: the low 2*WIDTH bits of a sign-extended multiply are exactly
  // the signed product, so one multiplier shape serves both flavours.
  logic [W2-1:0] a_sx, b_sx, a_zx, b_zx, prod_s, prod_u;

  assign a_sx   = {{WIDTH{a[WIDTH-1]}}, a};
  assign b_sx   = {{WIDTH{b[WIDTH-1]}}, b};
  assign a_zx   = {{WIDTH{1'b0}}, a};
  assign b_zx   = {{WIDTH{1'b0}}, b};
  assign prod_s = a_sx * b_sx;
  assign prod_u = a_zx * b_zx;

  // Divides: SV signed / and % already truncate toward zero with the
  // remainder following the dividend; zero divisor and MIN/-1 are handled
  // separately because the native operators give no defined result there.
  logic signed [WIDTH-1:0] a_s, b_s;
  logic [WIDTH-1:0]        q_s, r_s, q_u, r_u;
  logic                    div_zero, div_ovf;
  logic [WIDTH-1:0]        most_neg;

  assign a_s      = $signed(a);
  assign b_s      = $signed(b);
  assign q_s      = a_s / b_s;
  assign r_s      = a_s % b_s;
  assign q_u      = a / b;
  assign r_u      = a % b;
  assign most_neg = {1'b1, {(WIDTH-1){1'b0}}};
  assign div_zero = (b == '0);
  assign div_ovf  = (a == most_neg) && (b == '1);

  // Candidate {hi, lo} for the op currently on the inputs.
  always_comb begin
    // NOTE: every signal written in a combinational block gets a default
    // first, so no path leaves it unassigned and no latch is inferred.
    result = {hi, lo};
    case (op_sel)
      OP_MULT:  result = prod_s;
      OP_MULTU: result = prod_u;
      OP_MADD:  result = {hi, lo} + prod_s;
      OP_MSUB:  result = {hi, lo} - prod_s;
      OP_DIV: begin
        if (div_zero)     result = {a, {WIDTH{1'b1}}};
        else if (div_ovf) result = {{WIDTH{1'b0}}, most_neg};
        else              result = {r_s, q_s};
      end
      OP_DIVU: begin
        if (div_zero) result = {a, {WIDTH{1'b1}}};
        else          result = {r_u, q_u};
      end
      default:  result = {hi, lo};
    endcase
  end

  // Next-state logic: acceptance, countdown, commit and flush.
  always_comb begin
    next_state = state;
    next_count = count;
    accept     = 1'b0;
    commit     = 1'b0;
    case (state)
      ST_IDLE: begin
        accept = start && !flush;
        if (accept && arith) begin
          next_state = ST_RUN;
          next_count = is_div(op_sel) ? DIV_CNT : MUL_CNT;
        end
      end
      ST_RUN: begin
        if (flush) begin
          next_state = ST_IDLE;
          next_count = 8'd0;
        end else if (count <= 8'd1) begin
          next_state = ST_IDLE;
          next_count = 8'd0;
          commit     = 1'b1;
        end else begin
          next_count = count - 8'd1;
        end
      end
      default: begin
        next_state = ST_IDLE;
        next_count = 8'd0;
      end
    endcase
  end

  // State and counter registers.
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: registered state is always written with non-blocking <= so every
    // flop samples values from before the edge, independent of block order.
    if (!reset) begin
      state <= ST_IDLE;
      count <= 8'd0;
    end else begin
      state <= next_state;
      count <= next_count;
    end
  end

  // Parked result, HI/LO architectural registers and the done pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      // NOTE: result_q is a single register, not a memory array, so it is
      // cheap to reset and doing so keeps it free of X after power-up.
      result_q <= '0;
      hi       <= '0;
      lo       <= '0;
      done     <= 1'b0;
    end else begin
      done <= commit;
      if (accept && arith) result_q <= result;
      if (accept && op_sel == OP_MTHI) hi <= a;
      if (accept && op_sel == OP_MTLO) lo <= a;
      if (commit) {hi, lo} <= result_q;
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed vector table, hand-written
// flush/reset/busy-start sequences, and random ops against a plain-arithmetic
// model of HI/LO.
module tb_mult_div_unit;
  import mdu_pkg::*;

  localparam int W  = 32;
  localparam int ML = 5;
  localparam int DL = 10;

  logic         clk   = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic         flush = 1'b0;
  logic [2:0]   op    = 3'd0;
  logic [W-1:0] a     = '0;
  logic [W-1:0] b     = '0;
  logic         busy, done;
  logic [W-1:0] hi, lo;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] m_hi = '0;
  logic [W-1:0] m_lo = '0;

  mult_div_unit #(.WIDTH(W), .MUL_LAT(ML), .DIV_LAT(DL)) dut (
    .clk  (clk),
    .reset(reset),
    .start(start),
    .op   (op),
    .a    (a),
    .b    (b),
    .flush(flush),
    .busy (busy),
    .done (done),
    .hi   (hi),
    .lo   (lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic int lat_of(input op_e o);
    return (o == OP_DIV || o == OP_DIVU) ? DL : ML;
  endfunction

  // Architectural model: {hi,lo} updated with whole-number arithmetic.
  function automatic void model_exec(input op_e o, input logic [W-1:0] x, input logic [W-1:0] y);
    logic [63:0] acc, p_s, p_u;
    longint      sx, sy, q, r;
    sx  = longint'($signed(x));
    sy  = longint'($signed(y));
    p_s = 64'(sx * sy);
    p_u = {32'd0, x} * {32'd0, y};
    acc = {m_hi, m_lo};
    case (o)
      OP_MULT:  acc = p_s;
      OP_MULTU: acc = p_u;
      OP_MADD:  acc = acc + p_s;
      OP_MSUB:  acc = acc - p_s;
      OP_DIV: begin
        if (y == 0)                                      acc = {x, 32'hFFFF_FFFF};
        else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) acc = {32'd0, 32'h8000_0000};
        else begin
          q   = sx / sy;
          r   = sx % sy;
          acc = {r[31:0], q[31:0]};
        end
      end
      OP_DIVU: begin
        if (y == 0) acc = {x, 32'hFFFF_FFFF};
        else        acc = {x % y, x / y};
      end
      OP_MTHI:  acc[63:32] = x;
      OP_MTLO:  acc[31:0]  = x;
      default:  acc = acc;
    endcase
    {m_hi, m_lo} = acc;
  endfunction

  // Present one start on a negedge; scramble inputs right after acceptance.
  task automatic issue(input op_e o, input logic [W-1:0] x, input logic [W-1:0] y);
    @(negedge clk);
    start = 1'b1;
    op    = o;
    a     = x;
    b     = y;
    @(posedge clk);
    #1;
    start = 1'b0;
    op    = 3'($urandom_range(7));
    a     = $urandom;
    b     = $urandom;
  endtask

  // Arithmetic op: measure busy length, then check result and done pulse.
  task automatic run_arith(input string name, input op_e o, input logic [W-1:0] x,
                           input logic [W-1:0] y, input int exp_lat,
                           input logic [W-1:0] eh, input logic [W-1:0] el);
    int n;
    n = 0;
    issue(o, x, y);
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (busy) n++;
      else break;
    end
    check({name, " busy cycles"}, 64'(n), 64'(exp_lat));
    check({name, " done"}, 64'(done), 64'd1);
    check({name, " hi"}, 64'(hi), 64'(eh));
    check({name, " lo"}, 64'(lo), 64'(el));
    @(negedge clk);
    check({name, " done width"}, 64'(done), 64'd0);
  endtask

  // Move op: completes on the accepting edge with no busy and no done.
  task automatic do_move(input string name, input op_e o, input logic [W-1:0] x);
    model_exec(o, x, '0);
    issue(o, x, $urandom);
    @(negedge clk);
    check({name, " busy"}, 64'(busy), 64'd0);
    check({name, " done"}, 64'(done), 64'd0);
    check({name, " hi"}, 64'(hi), 64'(m_hi));
    check({name, " lo"}, 64'(lo), 64'(m_lo));
  endtask

  // Watch n cycles: hi/lo must match the model, busy and done stay low.
  task automatic quiet(input string name, input int n);
    bit bad_done, bad_busy, bad_hl;
    bad_done = 0; bad_busy = 0; bad_hl = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (done) bad_done = 1;
      if (busy) bad_busy = 1;
      if (hi !== m_hi || lo !== m_lo) bad_hl = 1;
    end
    check({name, " no done"}, 64'(bad_done), 64'd0);
    check({name, " no busy"}, 64'(bad_busy), 64'd0);
    check({name, " hi/lo held"}, 64'(bad_hl), 64'd0);
  endtask

  typedef struct {
    op_e          o;
    logic [W-1:0] x, y;
    logic [W-1:0] eh, el;
  } vec_t;

  vec_t tbl[8];

  initial begin
    tbl[0] = '{OP_MULT,  32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF, 32'hFFFF_FFFA};
    tbl[1] = '{OP_DIV,   32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
    tbl[2] = '{OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
    tbl[3] = '{OP_DIVU,  32'h0000_0007, 32'h0000_0000, 32'h0000_0007, 32'hFFFF_FFFF};
    tbl[4] = '{OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
    tbl[5] = '{OP_DIVU,  32'd100,       32'd7,         32'd2,         32'd14};
    tbl[6] = '{OP_DIV,   32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD};
    tbl[7] = '{OP_DIV,   32'h8000_0000, 32'h0000_0000, 32'h8000_0000, 32'hFFFF_FFFF};

    // Power-up reset.
    #1 reset = 1'b0;
    #2;
    check("reset busy", 64'(busy), 64'd0);
    check("reset done", 64'(done), 64'd0);
    check("reset hi", 64'(hi), 64'd0);
    check("reset lo", 64'(lo), 64'd0);
    @(negedge clk);
    reset = 1'b1;

    // Directed vectors.
    for (int i = 0; i < 8; i++) begin
      run_arith($sformatf("vec%0d", i), tbl[i].o, tbl[i].x, tbl[i].y,
                lat_of(tbl[i].o), tbl[i].eh, tbl[i].el);
      m_hi = tbl[i].eh;
      m_lo = tbl[i].el;
    end

    // MTHI, MTLO, then MADD accumulating on them.
    do_move("mthi", OP_MTHI, 32'h1234_5678);
    do_move("mtlo", OP_MTLO, 32'hFFFF_FFFF);
    run_arith("madd", OP_MADD, 32'd2, 32'd3, ML, 32'h1234_5679, 32'h0000_0005);
    model_exec(OP_MADD, 32'd2, 32'd3);
    run_arith("msub", OP_MSUB, 32'd2, 32'd4, ML, 32'h1234_5678, 32'hFFFF_FFFD);
    model_exec(OP_MSUB, 32'd2, 32'd4);

    // Flush in the third busy cycle while a MULT start is held.
    issue(OP_DIV, 32'd100, 32'd7);
    @(negedge clk);
    start = 1'b1; op = OP_MULT; a = 32'd3; b = 32'd3;
    @(negedge clk);
    @(negedge clk);
    check("flush3 busy before", 64'(busy), 64'd1);
    flush = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    flush = 1'b0;
    check("flush3 busy after", 64'(busy), 64'd0);
    quiet("flush3", 12);

    // Flush on the final busy cycle: still no commit.
    issue(OP_DIVU, 32'd50, 32'd3);
    repeat (DL) @(negedge clk);
    check("flushlast busy before", 64'(busy), 64'd1);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    check("flushlast busy after", 64'(busy), 64'd0);
    quiet("flushlast", 4);

    // Start held through a MULTU (as an MTHI) is ignored while busy.
    issue(OP_MULTU, 32'h10, 32'h10);
    model_exec(OP_MULTU, 32'h10, 32'h10);
    for (int i = 0; i < ML; i++) begin
      @(negedge clk);
      start = 1'b1; op = OP_MTHI; a = 32'hDEAD_BEEF;
    end
    @(negedge clk);
    start = 1'b0;
    check("busystart busy", 64'(busy), 64'd0);
    check("busystart done", 64'(done), 64'd1);
    check("busystart hi", 64'(hi), 64'(m_hi));
    check("busystart lo", 64'(lo), 64'(m_lo));
    quiet("busystart", 3);

    // Asynchronous reset in the middle of a MULT.
    do_move("pre-rst mthi", OP_MTHI, 32'hA5A5_A5A5);
    do_move("pre-rst mtlo", OP_MTLO, 32'h5A5A_5A5A);
    issue(OP_MULT, 32'd5, 32'd7);
    @(negedge clk);
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    check("midrst busy", 64'(busy), 64'd0);
    check("midrst hi", 64'(hi), 64'd0);
    check("midrst lo", 64'(lo), 64'd0);
    m_hi = '0;
    m_lo = '0;
    @(negedge clk);
    reset = 1'b1;
    quiet("postrst", 8);
    run_arith("postrst mult", OP_MULT, 32'hFFFF_FFFE, 32'd3, ML, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
    model_exec(OP_MULT, 32'hFFFF_FFFE, 32'd3);

    // Random ops against the model, biased toward divide corner cases.
    for (int i = 0; i < 40; i++) begin
      op_e          o;
      logic [W-1:0] x, y;
      int           sel;
      o   = op_e'(3'($urandom_range(7)));
      x   = $urandom;
      y   = $urandom;
      sel = $urandom_range(9);
      if (sel == 0) y = '0;
      else if (sel == 1) begin x = 32'h8000_0000; y = 32'hFFFF_FFFF; end
      else if (sel == 2) begin x = $urandom_range(200); y = $urandom_range(20); end
      if (is_move(o)) begin
        do_move($sformatf("rnd%0d", i), o, x);
      end else begin
        model_exec(o, x, y);
        run_arith($sformatf("rnd%0d", i), o, x, y, lat_of(o), m_hi, m_lo);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
